spi_flash_reader: RTL and testbench
===================================

# spi_flash_reader

Command sequencer that drives the `spi_master` byte engine to perform SPI-NOR READ (0x03) transactions. A client pulses `start` with a 24-bit flash address and a byte count. The block then:
- selects the target,
- shifts out the command and address,
- clocks dummy bytes to stream the read data back as single-cycle pulses,
- releases chip-select.

It sits between the boot/loader logic and `spi_master`, and is the only writer of that master's target and transmit controls.

## Interface
Parameters:
- NUM_TARGETS, 1, width of the target select vector (matches `spi_master`)
- CMD_READ, 8'h03, command opcode sent first
- DUMMY_TX, 8'hFF, byte transmitted during the data phase
- CS_GAP, 4, minimum clk cycles `target_en` stays low between transactions (≥1)
- LEN_W, 16, width of the length field

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (48 MHz)
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only when busy=0
- target  in  NUM_TARGETS  one-hot target for this transaction; latched at start
- addr  in  24  flash byte address; latched at start
- len  in  LEN_W  number of data bytes to read; latched at start
- abort  in  1  level or pulse; terminates the current transaction early
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at transaction end (normal or aborted)
- aborted  out  1  valid with done: 1 if ended by abort
- dout  out  8  received data byte
- dout_valid  out  1  one-cycle strobe qualifying dout; no backpressure
- target_id  out  NUM_TARGETS  to `spi_master`
- target_en  out  1  to `spi_master`; high for the whole transaction
- tx_byte  out  8  to `spi_master`
- tx_en  out  1  to `spi_master`; one-cycle enqueue strobe
- tx_ready  in  1  from `spi_master`
- rx_byte  in  8  from `spi_master`
- rx_en  in  1  from `spi_master`; one-cycle received-byte strobe

## Operation
- States: IDLE → SEL → CMD → A2 → A1 → A0 → DATA → DRAIN → GAP → IDLE.
- IDLE: on start, latch target, addr and len. Set target_id=target and target_en=1, then go to SEL.
- SEL: wait one cycle for chip-select setup, then go to CMD.
- Transmit-state rule (CMD, A2, A1, A0, DATA):
  - In the first cycle with tx_ready=1, drive tx_byte and pulse tx_en.
  - tx_ready is ignored in the cycle after tx_en, so a stale ready never causes a double enqueue.
  - Transmitted byte per state: CMD sends CMD_READ. A2, A1 and A0 send addr[23:16], addr[15:8] and addr[7:0].
  - DATA sends DUMMY_TX once per remaining data byte.
- Transitions between transmit states:
  - CMD → A2 → A1 → A0 each advance after their tx_en.
  - A0 advances to DATA after its tx_en when len≠0. When len=0 it goes to DRAIN.
  - DATA stays until tx_cnt=len dummy bytes have been enqueued, then goes to DRAIN.
- Receive counting: a counter of width LEN_W+3 counts rx_en pulses.
  - The first 4 rx_en pulses are discarded (command/address echo).
  - Every later rx_en produces dout=rx_byte with dout_valid=1 in the following cycle.
- DRAIN: wait until the rx count equals 4+len, i.e. the last byte has been received.
- GAP:
  - On entry, drop target_en.
  - Hold for CS_GAP cycles.
  - On the last GAP cycle, pulse done and set aborted. busy falls with done.
  - Return to IDLE.
- Abort:
  - Checked in SEL and every transmit state.
  - When asserted, no further tx_en is issued; go to DRAIN.
  - The drain target becomes the count of bytes actually enqueued, so an in-flight byte is completed and its data, if it is in the data phase, is still delivered.
  - Abort in DRAIN or GAP only sets aborted. Abort in IDLE is ignored.
- start while busy=1 is ignored.
- Simultaneous abort and start in IDLE: start is accepted and abort is ignored.
- Reset at any point returns to IDLE within one cycle. It forces target_en=0 with no gap, drops any pending rx, and emits no done.

## Timing
- Reset values:
  - target_en=0, target_id=0, tx_en=0, tx_byte=0.
  - busy=0, done=0, aborted=0, dout=0, dout_valid=0.
  - State IDLE, all counters 0.
- start to target_en=1: 1 cycle. start to first tx_en: at least 2 cycles.
- tx_en is never high on two consecutive cycles.
- Total tx_en pulses per unaborted transaction: exactly 4+len.
- rx_en to dout_valid: 1 cycle, registered.
- dout_valid never asserts after done in the same transaction.
- Last rx_en to target_en falling edge: 1 cycle.
- target_en falling edge to done: CS_GAP cycles, done on the last gap cycle.
- Earliest next start accepted: the cycle after done.

## Test plan
- Normal read: addr=24'h012345, len=3, MISO looped to MOSI, prescaler=1. Require:
  - tx sequence 03,01,23,45,FF,FF,FF;
  - exactly 3 dout_valid, each dout=FF;
  - done with aborted=0;
  - target_en high from start+1 until the last rx_en+1.
- Flash model returning A5,5A,C3 in the data phase. Require dout A5,5A,C3 in order and no dout_valid during the command/address bytes.
- len=0: require 4 tx_en, 0 dout_valid, and a done pulse CS_GAP cycles after target_en falls.
- Abort asserted during the 2nd DATA byte of a len=8 read. Require:
  - no tx_en after that byte;
  - that byte is still delivered (2 dout_valid total);
  - done with aborted=1.
- Back-to-back: a start pulse during busy is ignored (exactly one transaction). A start issued the cycle after done is accepted, and target_en stays low for at least CS_GAP cycles between transactions.
- reset asserted mid-ADDR: target_en=0 and busy=0 the next cycle, no done pulse, and a following start runs a clean transaction.

Source files
------------

// File: rtl/spi_flash_reader_if.sv
// Byte-engine side of the SPI flash reader: target select, transmit enqueue and
// received-byte strobe shared with spi_master.
interface spi_flash_reader_if #(
  parameter int unsigned NUM_TARGETS = 1
);
  logic [NUM_TARGETS-1:0] target_id;
  logic                   target_en;
  logic [7:0]             tx_byte;
  logic                   tx_en;
  logic                   tx_ready;
  logic [7:0]             rx_byte;
  logic                   rx_en;

  modport master (
    output target_id, target_en, tx_byte, tx_en,
    input  tx_ready, rx_byte, rx_en
  );

  modport slave (
    input  target_id, target_en, tx_byte, tx_en,
    output tx_ready, rx_byte, rx_en
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI-NOR READ (0x03) sequencer: selects the target, enqueues command, address and
// dummy bytes into spi_master, streams the received data bytes, then releases CS.
module spi_flash_reader #(
  parameter int unsigned NUM_TARGETS = 1,
  parameter logic [7:0]  CMD_READ    = 8'h03,
  parameter logic [7:0]  DUMMY_TX    = 8'hFF,
  parameter int unsigned CS_GAP      = 4,
  parameter int unsigned LEN_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_TARGETS-1:0] target,
  input  logic [23:0]            addr,
  input  logic [LEN_W-1:0]       len,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [7:0]             dout,
  output logic                   dout_valid,
  spi_flash_reader_if.master     spi
);

  localparam int unsigned CNT_W = LEN_W + 3;
  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_DRAIN, S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic                   busy_d, done_d, aborted_d, dout_valid_d;
  logic [7:0]             dout_d;
  logic [NUM_TARGETS-1:0] target_id_d;
  logic                   target_en_d, tx_en_d;
  logic [7:0]             tx_byte_d;
  logic [23:0]            addr_q, addr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [CNT_W-1:0]       enq_cnt, enq_d;
  logic [CNT_W-1:0]       rx_cnt, rx_d;
  logic [GAP_W-1:0]       gap_cnt, gap_d;
  logic                   abort_seen, abort_seen_d;

  logic                   tx_ok;
  logic [CNT_W-1:0]       total_tx;
  logic [7:0]             tx_pick;
  state_t                 tx_next;

  // A ready seen in the cycle right after an enqueue is stale and is ignored.
  assign tx_ok    = spi.tx_ready && !spi.tx_en;
  assign total_tx = CNT_W'(len_q) + CNT_W'(4);

  always_comb begin : next_state_c
    state_d      = state_q;
    busy_d       = busy;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    dout_d       = dout;
    dout_valid_d = 1'b0;
    target_id_d  = spi.target_id;
    target_en_d  = spi.target_en;
    tx_byte_d    = spi.tx_byte;
    tx_en_d      = 1'b0;
    addr_d       = addr_q;
    len_d        = len_q;
    enq_d        = enq_cnt;
    rx_d         = rx_cnt;
    gap_d        = gap_cnt;
    abort_seen_d = abort_seen;
    tx_pick      = CMD_READ;
    tx_next      = S_A2;

    // Byte and successor for whichever transmit state is active.
    case (state_q)
      S_A2:    begin tx_pick = addr_q[23:16]; tx_next = S_A1; end
      S_A1:    begin tx_pick = addr_q[15:8];  tx_next = S_A0; end
      S_A0:    begin
        tx_pick = addr_q[7:0];
        tx_next = (len_q == '0) ? S_DRAIN : S_DATA;
      end
      S_DATA:  begin
        tx_pick = DUMMY_TX;
        tx_next = ((enq_cnt + CNT_W'(1)) == total_tx) ? S_DRAIN : S_DATA;
      end
      default: begin tx_pick = CMD_READ; tx_next = S_A2; end
    endcase

    // The first four received bytes are the command/address echo.
    if (state_q != S_IDLE && spi.rx_en) begin
      rx_d = rx_cnt + CNT_W'(1);
      if (rx_cnt >= CNT_W'(4)) begin
        dout_d       = spi.rx_byte;
        dout_valid_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !done) begin
          addr_d       = addr;
          len_d        = len;
          target_id_d  = target;
          target_en_d  = 1'b1;
          busy_d       = 1'b1;
          enq_d        = '0;
          rx_d         = '0;
          gap_d        = '0;
          abort_seen_d = 1'b0;
          state_d      = S_SEL;
        end
      end
      S_SEL: begin
        if (abort) begin
          abort_seen_d = 1'b1;
          state_d      = S_DRAIN;
        end else begin
          state_d = S_CMD;
        end
      end
      S_CMD, S_A2, S_A1, S_A0, S_DATA: begin
        if (abort) begin
          abort_seen_d = 1'b1;
          state_d      = S_DRAIN;
        end else if (tx_ok) begin
          tx_en_d   = 1'b1;
          tx_byte_d = tx_pick;
          enq_d     = enq_cnt + CNT_W'(1);
          state_d   = tx_next;
        end
      end
      // Every enqueued byte, including one in flight at abort, must come back.
      S_DRAIN: begin
        if (abort) abort_seen_d = 1'b1;
        if (rx_d == enq_cnt) begin
          target_en_d = 1'b0;
          gap_d       = '0;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (abort) abort_seen_d = 1'b1;
        if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
          done_d    = 1'b1;
          aborted_d = abort_seen | abort;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          gap_d = gap_cnt + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q       <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      dout          <= '0;
      dout_valid    <= 1'b0;
      spi.target_id <= '0;
      spi.target_en <= 1'b0;
      spi.tx_byte   <= '0;
      spi.tx_en     <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      enq_cnt       <= '0;
      rx_cnt        <= '0;
      gap_cnt       <= '0;
      abort_seen    <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy          <= busy_d;
      done          <= done_d;
      aborted       <= aborted_d;
      dout          <= dout_d;
      dout_valid    <= dout_valid_d;
      spi.target_id <= target_id_d;
      spi.target_en <= target_en_d;
      spi.tx_byte   <= tx_byte_d;
      spi.tx_en     <= tx_en_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      enq_cnt       <= enq_d;
      rx_cnt        <= rx_d;
      gap_cnt       <= gap_d;
      abort_seen    <= abort_seen_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: behavioural spi_master/flash model with
// random ready and shift latency, and a frame-level reference of each READ.
module tb_spi_flash_reader;

  localparam int CS_GAP = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [0:0]  target;
  logic [23:0] addr;
  logic [15:0] len;
  logic        abort;
  logic        busy, done, aborted, dout_valid;
  logic [7:0]  dout;

  spi_flash_reader_if #(.NUM_TARGETS(1)) spi_if ();

  spi_flash_reader #(
    .NUM_TARGETS(1), .CMD_READ(8'h03), .DUMMY_TX(8'hFF), .CS_GAP(CS_GAP), .LEN_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .target(target), .addr(addr),
    .len(len), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .dout(dout), .dout_valid(dout_valid), .spi(spi_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         mode;                 // 0: MISO looped to MOSI, 1: flash array
  logic [7:0] mem [256];

  // Monitor state
  logic [7:0] tx_log[$];
  logic [7:0] dout_log[$];
  int  cyc = 0, first_tx_cyc = -1, last_rx_cyc = 0, fall_cyc = 0, done_cyc = 0;
  int  done_cnt = 0, dbl_tx = 0, late_dv = 0, short_gap = 0;
  bit  prev_tx_en = 0, prev_ten = 0, have_fall = 0, done_seen = 0, done_ab = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // spi_master + flash: queue of enqueued bytes, each returned after a random delay.
  initial begin : spi_master_model
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic [23:0] fa;
    int          cd, idx;
    bit          sh;
    spi_if.tx_ready = 1'b0;
    spi_if.rx_en    = 1'b0;
    spi_if.rx_byte  = 8'h00;
    sh = 0; cd = 0; idx = 0; fa = 24'h0;
    forever begin
      @(negedge clk); #1;
      spi_if.rx_en = 1'b0;
      if (reset) begin
        q.delete();
        sh = 0;
        idx = 0;
        spi_if.tx_ready = 1'b0;
      end else begin
        if (!spi_if.target_en) idx = 0;
        if (spi_if.tx_en) q.push_back(spi_if.tx_byte);
        if (sh) begin
          if (cd == 0) begin
            b = q.pop_front();
            if (idx >= 1 && idx <= 3) fa = {fa[15:0], b};
            if (mode == 1'b0)  spi_if.rx_byte = b;
            else if (idx < 4)  spi_if.rx_byte = 8'h00;
            else               spi_if.rx_byte = mem[8'(fa[7:0] + 8'(idx - 4))];
            spi_if.rx_en = 1'b1;
            idx++;
            sh = 0;
          end else begin
            cd--;
          end
        end else if (q.size() != 0) begin
          sh = 1;
          cd = $urandom_range(1, 4);
        end
        spi_if.tx_ready = (q.size() < 2) && ($urandom_range(0, 3) != 0);
      end
    end
  end

  always @(posedge clk) begin : monitor
    #1;
    cyc++;
    if (spi_if.tx_en) begin
      if (prev_tx_en) dbl_tx++;
      tx_log.push_back(spi_if.tx_byte);
      if (tx_log.size() == 1) first_tx_cyc = cyc;
    end
    prev_tx_en = spi_if.tx_en;
    if (dout_valid) begin
      dout_log.push_back(dout);
      if (done_seen) late_dv++;
    end
    if (spi_if.rx_en) last_rx_cyc = cyc;
    if (prev_ten && !spi_if.target_en) begin
      fall_cyc  = cyc;
      have_fall = 1;
    end
    if (!prev_ten && spi_if.target_en && have_fall && (cyc - fall_cyc < CS_GAP)) short_gap++;
    prev_ten = spi_if.target_en;
    if (reset) have_fall = 0;
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_ab   = aborted;
      done_seen = 1;
    end
  end

  // One READ; starts in the cycle after the previous call saw done.
  task automatic run_txn(input logic [23:0] a, input int n, input bit do_abort,
                         input int abort_tx, input bit busy_start);
    logic [7:0] exp_tx[$];
    logic [7:0] exp_dv[$];
    int d0, s_cyc, n_tx, n_dv;
    bit ab_sent;
    exp_tx = '{8'h03, a[23:16], a[15:8], a[7:0]};
    for (int i = 0; i < n; i++) exp_tx.push_back(8'hFF);
    n_tx = do_abort ? abort_tx : 4 + n;
    n_dv = (n_tx > 4) ? n_tx - 4 : 0;
    for (int i = 0; i < n_dv; i++) exp_dv.push_back(mode ? mem[8'(a[7:0] + i)] : 8'hFF);

    @(negedge clk);
    @(negedge clk);
    tx_log.delete();
    dout_log.delete();
    done_seen = 0;
    first_tx_cyc = -1;
    d0 = done_cnt;
    start = 1'b1; addr = a; len = 16'(n); target = 1'b1;
    @(posedge clk); #2;
    s_cyc = cyc;
    chk("target_en_start+1", 32'(spi_if.target_en), 1);
    chk("busy_start+1", 32'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    ab_sent = 0;
    for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
      @(posedge clk); #2;
      if (busy_start && k == 2) begin
        chk("busy_at_restart", 32'(busy), 1);
        @(negedge clk); start = 1'b1; addr = ~a; len = 16'(n + 3);
        @(negedge clk); start = 1'b0;
      end
      if (do_abort && !ab_sent && tx_log.size() >= abort_tx) begin
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        ab_sent = 1;
      end
    end
    chk("done_pulses", 32'(done_cnt - d0), 1);
    chk("aborted", 32'(done_ab), 32'(do_abort));
    chk("tx_count", 32'(tx_log.size()), 32'(n_tx));
    for (int i = 0; i < n_tx && i < tx_log.size(); i++)
      chk($sformatf("tx_byte[%0d]", i), 32'(tx_log[i]), 32'(exp_tx[i]));
    chk("dout_count", 32'(dout_log.size()), 32'(n_dv));
    for (int i = 0; i < n_dv && i < dout_log.size(); i++)
      chk($sformatf("dout[%0d]", i), 32'(dout_log[i]), 32'(exp_dv[i]));
    chk("start_to_first_tx_ge2", 32'(first_tx_cyc - s_cyc >= 2), 1);
    chk("last_rx_to_cs_fall", 32'(fall_cyc - last_rx_cyc), 0);
    chk("cs_fall_to_done", 32'(done_cyc - fall_cyc), 32'(CS_GAP));
  endtask

  initial begin : stimulus
    int d0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; target = 1'b1; addr = '0; len = '0;
    mode = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #2;
    chk("rst_target_en", 32'(spi_if.target_en), 0);
    chk("rst_target_id", 32'(spi_if.target_id), 0);
    chk("rst_tx_en", 32'(spi_if.tx_en), 0);
    chk("rst_tx_byte", 32'(spi_if.tx_byte), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_aborted", 32'(aborted), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    @(negedge clk);
    reset = 1'b0;

    // Loopback read, then flash data A5,5A,C3, then zero-length read
    mode = 1'b0;
    run_txn(24'h012345, 3, 1'b0, 0, 1'b0);
    mode = 1'b1;
    mem[8'h45] = 8'hA5; mem[8'h46] = 8'h5A; mem[8'h47] = 8'hC3;
    run_txn(24'h012345, 3, 1'b0, 0, 1'b0);
    run_txn(24'h00FF10, 0, 1'b0, 0, 1'b0);

    // Abort right after the 2nd dummy byte is enqueued
    mode = 1'b1;
    run_txn(24'h123480, 8, 1'b1, 6, 1'b0);

    // Start during busy is ignored; the following start lands the cycle after done
    mode = 1'b0;
    run_txn(24'hABCDEF, 2, 1'b0, 0, 1'b1);
    run_txn(24'h000102, 1, 1'b0, 0, 1'b0);

    // Reset while address bytes are going out
    @(negedge clk);
    @(negedge clk);
    tx_log.delete();
    d0 = done_cnt;
    start = 1'b1; addr = 24'h55AA33; len = 16'd5;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300 && tx_log.size() < 2; k++) begin
      @(posedge clk); #2;
    end
    chk("reached_addr_phase", 32'(tx_log.size() >= 2), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    chk("reset_target_en", 32'(spi_if.target_en), 0);
    chk("reset_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("no_done_after_reset", 32'(done_cnt - d0), 0);
    mode = 1'b1;
    run_txn(24'h55AA33, 5, 1'b0, 0, 1'b0);

    // Randomised reads
    for (int t = 0; t < 6; t++) begin
      mode = 1'($urandom_range(0, 1));
      run_txn(24'($urandom), $urandom_range(0, 6), 1'b0, 0, 1'b0);
    end

    chk("tx_en_back_to_back", 32'(dbl_tx), 0);
    chk("dout_valid_after_done", 32'(late_dv), 0);
    chk("cs_gap_short", 32'(short_gap), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
